// File: rtl/gate_bist_ctrl.sv
// Built-in self-test sequencer for a three-input gate: walks all eight {a,b,c} vectors,
// samples d/e at the end of each hold window and reports pass/fail, error count and first bad vector.
module gate_bist_ctrl #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [7:0]  EXP_D       = 8'h80,
    parameter logic [7:0]  EXP_E       = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    input  logic       d_i,
    input  logic       e_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic       aborted,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 2);

    state_t     r_state;
    logic [7:0] r_hold;
    logic [2:0] r_vec;
    logic [2:0] r_stim;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic       r_aborted;
    logic [3:0] r_err;
    logic [2:0] r_fail;

    logic       w_mismatch;
    logic [3:0] w_err_next;

    // A mismatch on either output is a single error for this vector.
    assign w_mismatch = (d_i != EXP_D[r_vec]) || (e_i != EXP_E[r_vec]);
    assign w_err_next = r_err + 4'(w_mismatch);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_hold    <= '0;
            r_vec     <= '0;
            r_stim    <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_aborted <= 1'b0;
            r_err     <= '0;
            r_fail    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state   <= S_SETTLE;
                        r_err     <= '0;
                        r_fail    <= '0;
                        r_pass    <= 1'b0;
                        r_aborted <= 1'b0;
                        r_vec     <= '0;
                        r_hold    <= '0;
                        r_stim    <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_stim    <= '0;
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else if (r_hold == HOLD_LAST) begin
                        r_state <= S_SAMPLE;
                    end else begin
                        r_hold <= r_hold + 8'd1;
                    end
                end
                S_SAMPLE: begin
                    // Abort wins over the sample, and that cycle's comparison is dropped.
                    if (abort) begin
                        r_state   <= S_DONE;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_stim    <= '0;
                        r_aborted <= 1'b1;
                        r_pass    <= 1'b0;
                    end else begin
                        r_err <= w_err_next;
                        if (w_mismatch && (r_err == 4'd0)) begin
                            r_fail <= r_vec;
                        end
                        if (r_vec == 3'd7) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_stim  <= '0;
                            r_pass  <= (w_err_next == 4'd0);
                        end else begin
                            r_state <= S_SETTLE;
                            r_vec   <= r_vec + 3'd1;
                            r_stim  <= r_vec + 3'd1;
                            r_hold  <= '0;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign a_o      = r_stim[2];
    assign b_o      = r_stim[1];
    assign c_o      = r_stim[0];
    assign busy     = r_busy;
    assign done     = r_done;
    assign pass     = r_pass;
    assign aborted  = r_aborted;
    assign err_cnt  = r_err;
    assign fail_vec = r_fail;

endmodule

// File: tb/tb_gate_bist_ctrl.sv
// Directed bench for gate_bist_ctrl: a behavioural gate model (d = a&b&c, e = ~(a|b|c))
// with injectable faults, plus a second instance at HOLD_CYCLES = 2 with start held high.
module tb_gate_bist_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       a_o, b_o, c_o;
    logic       d_i, e_i;
    logic       busy, done, pass, aborted;
    logic [3:0] err_cnt;
    logic [2:0] fail_vec;

    logic       start2;
    logic       abort2;
    logic       a2, b2, c2;
    logic       d2, e2;
    logic       busy2, done2, pass2, aborted2;
    logic [3:0] err_cnt2;
    logic [2:0] fail_vec2;

    logic       flt_d0;
    logic       flt_einv;

    int n_checks;
    int n_fail;

    assign d_i = flt_d0 ? 1'b0 : (a_o & b_o & c_o);
    assign e_i = flt_einv ^ ~(a_o | b_o | c_o);
    assign d2  = a2 & b2 & c2;
    assign e2  = ~(a2 | b2 | c2);

    gate_bist_ctrl #(.HOLD_CYCLES(4), .EXP_D(8'h80), .EXP_E(8'h01)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_i(d_i), .e_i(e_i),
        .busy(busy), .done(done), .pass(pass), .aborted(aborted),
        .err_cnt(err_cnt), .fail_vec(fail_vec)
    );

    gate_bist_ctrl #(.HOLD_CYCLES(2), .EXP_D(8'h80), .EXP_E(8'h01)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(abort2),
        .a_o(a2), .b_o(b2), .c_o(c2), .d_i(d2), .e_i(e2),
        .busy(busy2), .done(done2), .pass(pass2), .aborted(aborted2),
        .err_cnt(err_cnt2), .fail_vec(fail_vec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Full run of the default instance from IDLE; returns in IDLE one cycle after done.
    task automatic do_run(input logic [3:0] e_err, input logic [2:0] e_fail, input logic e_pass);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("run_busy", busy, 1);
            tick();
        end
        chk("run_done", done, 1);
        chk("run_busy_low", busy, 0);
        chk("run_err", err_cnt, e_err);
        chk("run_fail", fail_vec, e_fail);
        chk("run_pass", pass, e_pass);
        chk("run_aborted", aborted, 0);
        chk("run_stim0", {a_o, b_o, c_o}, 0);
        tick();
        chk("run_done_low", done, 0);
        chk("run_pass_hold", pass, e_pass);
        chk("run_err_hold", err_cnt, e_err);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;
        start2   = 1'b0;
        abort2   = 1'b0;
        flt_d0   = 1'b0;
        flt_einv = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_stim", {a_o, b_o, c_o}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_pass", pass, 0);
        chk("rst_aborted", aborted, 0);
        chk("rst_err", err_cnt, 0);
        chk("rst_fail", fail_vec, 0);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        // Correct gate: vector k held 4 cycles, start pulse mid-run ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            for (int h = 0; h < 4; h++) begin
                chk("t1_stim", {a_o, b_o, c_o}, k);
                chk("t1_busy", busy, 1);
                chk("t1_done", done, 0);
                start = (k == 3 && h == 1);
                tick();
            end
        end
        start = 1'b0;
        chk("t1_done", done, 1);
        chk("t1_busy_low", busy, 0);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_cnt, 0);
        chk("t1_aborted", aborted, 0);
        chk("t1_stim0", {a_o, b_o, c_o}, 0);
        tick();
        chk("t1_done_low", done, 0);
        chk("t1_pass_hold", pass, 1);

        // d stuck at 0: only vector 7 expects d = 1
        flt_d0 = 1'b1;
        do_run(4'd1, 3'd7, 1'b0);
        flt_d0 = 1'b0;

        // e inverted: every vector fails, first is 0
        flt_einv = 1'b1;
        do_run(4'd8, 3'd0, 1'b0);

        // Abort in vector 4 SETTLE, errors on every vector so far
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("ab_stim4", {a_o, b_o, c_o}, 4);
        chk("ab_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_done", done, 1);
        chk("ab_aborted", aborted, 1);
        chk("ab_pass", pass, 0);
        chk("ab_err", err_cnt, 4);
        chk("ab_fail", fail_vec, 0);
        chk("ab_stim0", {a_o, b_o, c_o}, 0);
        chk("ab_busy_low", busy, 0);
        tick();
        chk("ab_done_low", done, 0);
        chk("ab_aborted_hold", aborted, 1);
        chk("ab_err_hold", err_cnt, 4);

        // Reset during vector 2
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        chk("rm_stim2", {a_o, b_o, c_o}, 2);
        chk("rm_err_pre", err_cnt, 2);
        rst = 1'b1;
        tick();
        chk("rm_stim", {a_o, b_o, c_o}, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        chk("rm_pass", pass, 0);
        chk("rm_aborted", aborted, 0);
        chk("rm_err", err_cnt, 0);
        chk("rm_fail", fail_vec, 0);
        rst      = 1'b0;
        flt_einv = 1'b0;

        // Clean run afterwards, with start and abort together in IDLE
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 1);
        for (int i = 0; i < 32; i++) tick();
        chk("sa_done", done, 1);
        chk("sa_pass", pass, 1);
        chk("sa_err", err_cnt, 0);
        chk("sa_aborted", aborted, 0);
        tick();

        // HOLD_CYCLES = 2 with start held: one done every 18 cycles
        start2 = 1'b1;
        tick();
        chk("h2_busy", busy2, 1);
        for (int i = 0; i < 16; i++) tick();
        chk("h2_done0", done2, 1);
        chk("h2_pass0", pass2, 1);
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("h2_idle_busy", busy2, 0);
            chk("h2_gap_done", done2, 0);
            for (int i = 0; i < 16; i++) begin
                tick();
                chk("h2_gap_done", done2, 0);
                chk("h2_gap_busy", busy2, 1);
            end
            tick();
            chk("h2_done", done2, 1);
            chk("h2_pass", pass2, 1);
            chk("h2_err", err_cnt2, 0);
            chk("h2_fail", fail_vec2, 0);
            chk("h2_aborted", aborted2, 0);
            chk("h2_stim0", {a2, b2, c2}, 0);
        end
        start2 = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
